// File: rtl/uart_byte_rx_pkg.sv
// Definitions shared by the UART byte transmitter and receiver:
// line-level bit values and the clocks-per-bit computation.
package uart_byte_rx_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int unsigned calc_bps(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous UART pin, plus a delayed copy
// used to flag a clean high-to-low transition on the synchronized line.
module uart_rx_sync (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic rx_async,
    output logic sync2,
    output logic rx_fall
);

    logic sync1;
    logic sync2_d;

    // Idle line is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
        end else begin
            sync1   <= rx_async;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rx_fall = sync2_d & ~sync2;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: mid-bit start validation, 8 data bits LSB-first,
// stop-bit check, one-cycle done / framing-error pulses.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 'd50000000,
    parameter int unsigned BAUD_RATE = 'd9600
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_state,
    output logic       frame_err
);

    localparam int unsigned BPS  = calc_bps(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF = BPS / 2;
    localparam logic [15:0] BPS_END  = 16'(BPS - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        sync2;
    logic        rx_fall;

    uart_rx_sync u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rx_async (rs232_rx),
        .sync2    (sync2),
        .rx_fall  (rx_fall)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_state  <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (rx_fall) begin
                        state    <= START;
                        rx_state <= 1'b1;
                    end
                end
                // A start bit that is high again at its centre was a glitch.
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= 16'd0;
                        if (sync2 == START_BIT) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state    <= IDLE;
                            rx_state <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BPS_END) begin
                        cnt   <= 16'd0;
                        shreg <= {sync2, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // Leaving at mid-stop-bit gives half a bit of slack for back-to-back frames.
                STOP: begin
                    if (cnt == BPS_END) begin
                        cnt      <= 16'd0;
                        state    <= IDLE;
                        rx_state <= 1'b0;
                        if (sync2 == STOP_BIT) begin
                            rx_data <= shreg;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: fast instance (BPS=10) for the functional
// cases and a default-parameter instance for the long-period timing case.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_state, frame_err;
    logic       rx2 = 1'b1;
    logic [7:0] rx_data2;
    logic       rx_done2, rx_state2, frame_err2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done_cyc [16];
    logic [7:0] done_dat [16];
    int rise_cyc = -1, fall_cyc = -1;
    logic st_prev = 1'b0;
    int done2_cnt = 0, done2_cyc = -1, err2_cnt = 0;
    logic [7:0] done2_dat = 8'h00;

    uart_byte_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .rs232_rx  (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_state  (rx_state),
        .frame_err (frame_err)
    );

    uart_byte_rx dut_def (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .rs232_rx  (rx2),
        .rx_data   (rx_data2),
        .rx_done   (rx_done2),
        .rx_state  (rx_state2),
        .frame_err (frame_err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder; at a falling edge cyc equals the number of rising edges so far.
    always @(negedge clk) begin
        if (rx_done) begin
            if (done_cnt < 16) begin
                done_cyc[done_cnt] = cyc;
                done_dat[done_cnt] = rx_data;
            end
            done_cnt++;
        end
        if (frame_err) err_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if (rx_state && !st_prev) rise_cyc = cyc;
        if (!rx_state && st_prev) fall_cyc = cyc;
        st_prev = rx_state;
        if (rx_done2) begin
            done2_cnt++;
            done2_cyc = cyc;
            done2_dat = rx_data2;
        end
        if (frame_err2) err2_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns k: the edge at which the start bit is first captured.
    task automatic send_byte(input logic [7:0] d, input logic stop, output int k);
        k = cyc + 1;
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(10);
        end
        rx = stop;
        tick(10);
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, d0, e0;
        tick(1);
        tick(3);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_done", rx_done, 1'b0);
        chk("reset_rx_state", rx_state, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // Single byte
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1, k);
        tick(5);
        chk("a5_done_count", done_cnt - d0, 1);
        chk("a5_done_edge", done_cyc[d0], k + 97);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_no_ferr", err_cnt - e0, 0);
        chk("a5_state_rise", rise_cyc, k + 2);
        chk("a5_state_fall", fall_cyc, k + 97);

        // Start glitch
        d0 = done_cnt; e0 = err_cnt;
        k = cyc + 1;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        chk("glitch_no_done", done_cnt - d0, 0);
        chk("glitch_no_ferr", err_cnt - e0, 0);
        chk("glitch_state_rise", rise_cyc, k + 2);
        chk("glitch_state_fall", fall_cyc, k + 7);
        chk("glitch_data_held", rx_data, 8'hA5);

        // Framing error followed by a held-low line
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h3C, 1'b0, k);
        rx = 1'b0;
        tick(50);
        chk("ferr_count", err_cnt - e0, 1);
        chk("ferr_no_done", done_cnt - d0, 0);
        chk("ferr_data_held", rx_data, 8'hA5);
        chk("ferr_idle_while_low", rx_state, 1'b0);
        rx = 1'b1;
        tick(20);
        chk("ferr_no_restart", rise_cyc, k + 2);

        // Back-to-back frames
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b1, k);
        send_byte(8'hFF, 1'b1, k2);
        tick(10);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_first_data", done_dat[d0], 8'h00);
        chk("b2b_second_data", done_dat[d0 + 1], 8'hFF);
        chk("b2b_spacing", done_cyc[d0 + 1] - done_cyc[d0], 100);
        chk("b2b_first_edge", done_cyc[d0], k + 97);
        chk("b2b_no_ferr", err_cnt - e0, 0);

        // Reset during data bit 4 of 8'h5A
        d0 = done_cnt;
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h5A >> i) & 8'h01;
            tick(10);
        end
        rx = 1'b1;
        tick(5);
        chk("rst_mid_busy", rx_state, 1'b1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_done", rx_done, 1'b0);
        chk("rst_mid_ferr", frame_err, 1'b0);
        chk("rst_mid_state", rx_state, 1'b0);
        tick(30);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        send_byte(8'h81, 1'b1, k);
        tick(5);
        chk("after_rst_done", done_cnt - d0, 1);
        chk("after_rst_data", rx_data, 8'h81);

        chk("never_done_and_ferr", both_cnt, 0);

        // Default parameters: BPS = 5208, HALF = 2604
        k = cyc + 1;
        rx2 = 1'b0;
        tick(5208);
        for (int i = 0; i < 8; i++) begin
            rx2 = (8'h01 >> i) & 8'h01;
            tick(5208);
        end
        rx2 = 1'b1;
        tick(5208);
        tick(10);
        chk("def_done_count", done2_cnt, 1);
        chk("def_done_edge", done2_cyc, k + 49478);
        chk("def_data", done2_dat, 8'h01);
        chk("def_no_ferr", err2_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
